// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_pkg                                                  |
// | Brief    : Shared UART state encodings and default frame parameters |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package uart_pkg;

   localparam logic [1:0] IDLE  = 2'b00;
   localparam logic [1:0] START = 2'b01;
   localparam logic [1:0] DATA  = 2'b10;
   localparam logic [1:0] STOP  = 2'b11;

   localparam int DEFAULT_DATA_LENGTH  = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 16;

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_rx_sync                                              |
// | Brief    : Two-flop rx synchronizer with falling-edge detect         |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic rx,
   output logic rx_s,
   output logic fall_edge
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   // Reset to the idle level so a line low at reset release reads as an edge
   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
         r_prev <= 1'b1;
      end else begin
         r_meta <= rx;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign rx_s      = r_sync;
   assign fall_edge = r_prev & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_rx                                                   |
// | Brief    : Oversampled UART receiver, 1 start / N data / 1 stop bit  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_LENGTH   = DEFAULT_DATA_LENGTH,
   parameter int CLKS_PER_BIT  = DEFAULT_CLKS_PER_BIT,
   parameter int CNT_WIDTH     = $clog2(CLKS_PER_BIT),
   parameter int BIT_CNT_WIDTH = $clog2(DATA_LENGTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rx,
   output logic [DATA_LENGTH-1:0] dout,
   output logic                   rx_valid,
   output logic                   rx_busy,
   output logic                   frame_err
);

   localparam logic [CNT_WIDTH-1:0]     c_half_last = CNT_WIDTH'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_WIDTH-1:0]     c_bit_last  = CNT_WIDTH'(CLKS_PER_BIT - 1);
   localparam logic [BIT_CNT_WIDTH-1:0] c_last_bit  = BIT_CNT_WIDTH'(DATA_LENGTH - 1);

   logic                     w_rx_s;
   logic                     w_fall;
   logic [1:0]               r_state;
   logic [CNT_WIDTH-1:0]     r_clk_cnt;
   logic [BIT_CNT_WIDTH-1:0] r_bit_cnt;
   logic [DATA_LENGTH-1:0]   r_shreg;

   uart_rx_sync u_sync (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .rx_s      (w_rx_s),
      .fall_edge (w_fall)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_clk_cnt <= '0;
         r_bit_cnt <= '0;
         r_shreg   <= '0;
         dout      <= '0;
         rx_valid  <= 1'b0;
         rx_busy   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_fall) begin
                  r_state   <= START;
                  r_clk_cnt <= '0;
                  r_bit_cnt <= '0;
                  rx_busy   <= 1'b1;
               end
            end
            START: begin
               if (r_clk_cnt == c_half_last) begin
                  r_clk_cnt <= '0;
                  r_bit_cnt <= '0;
                  // A high line at mid-start is a glitch, not a frame
                  if (!w_rx_s) begin
                     r_state <= DATA;
                  end else begin
                     r_state <= IDLE;
                     rx_busy <= 1'b0;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + 1'b1;
               end
            end
            DATA: begin
               if (r_clk_cnt == c_bit_last) begin
                  r_clk_cnt <= '0;
                  r_shreg   <= {w_rx_s, r_shreg[DATA_LENGTH-1:1]};
                  if (r_bit_cnt == c_last_bit) begin
                     r_state   <= STOP;
                     r_bit_cnt <= '0;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + 1'b1;
               end
            end
            STOP: begin
               if (r_clk_cnt == c_bit_last) begin
                  r_clk_cnt <= '0;
                  r_state   <= IDLE;
                  rx_busy   <= 1'b0;
                  if (w_rx_s) begin
                     dout     <= r_shreg;
                     rx_valid <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + 1'b1;
               end
            end
            default: begin
               r_state   <= IDLE;
               r_clk_cnt <= '0;
               r_bit_cnt <= '0;
               rx_busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_uart_rx                                                |
// | Brief    : Frame-level scoreboard bench for uart_rx                  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_uart_rx;

   localparam int DL     = 8;
   localparam int CPB    = 16;
   localparam int CLK_NS = 10;
   localparam int BIT_NS = CPB * CLK_NS;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          rx  = 1'b1;
   logic [DL-1:0] dout;
   logic          rx_valid;
   logic          rx_busy;
   logic          frame_err;

   uart_rx #(
      .DATA_LENGTH  (DL),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .dout      (dout),
      .rx_valid  (rx_valid),
      .rx_busy   (rx_busy),
      .frame_err (frame_err)
   );

   always #(CLK_NS / 2) clk = ~clk;

   typedef struct {
      bit            is_valid;
      logic [DL-1:0] data;
   } ev_t;

   typedef struct {
      logic [DL-1:0] data;
      logic          stop;
      int            gap;
      bit            jit;
   } vec_t;

   ev_t           obs[$];
   logic          obs_busy[$];
   ev_t           exp_q[$];
   logic [DL-1:0] model_dout = '0;
   int            overlap = 0;
   int            checks  = 0;
   int            passes  = 0;

   // Every strobe cycle becomes one event; a two-cycle strobe shows up as an extra event
   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid && frame_err) overlap++;
         if (rx_valid || frame_err) begin
            obs.push_back('{rx_valid, dout});
            obs_busy.push_back(rx_busy);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Sender plus reference model: a good stop publishes the word, a bad stop re-reports the last good word
   task automatic send_frame(input logic [DL-1:0] d, input logic stop, input int gap,
                             input bit jit, input bit record);
      logic [DL+1:0] bits;
      bits = {stop, d, 1'b0};
      if (record) begin
         if (stop) begin
            exp_q.push_back('{1'b1, d});
            model_dout = d;
         end else begin
            exp_q.push_back('{1'b0, model_dout});
         end
      end
      for (int i = 0; i < DL + 2; i++) begin
         rx = bits[i];
         if (jit) #((i % 2) ? BIT_NS + 5 : BIT_NS - 5);
         else     #(BIT_NS);
      end
      if (gap > 0) begin
         rx = 1'b1;
         repeat (gap) #(BIT_NS);
      end
   endtask

   task automatic drain(input string name);
      ev_t  e;
      ev_t  x;
      logic b;
      int   n;
      while (exp_q.size() > 0) begin
         n = 0;
         while (obs.size() == 0 && n < 400) begin
            @(negedge clk);
            n++;
         end
         chk({name, "_event_seen"}, 32'(obs.size() != 0), 32'd1);
         if (obs.size() == 0) begin
            exp_q.delete();
            return;
         end
         e = obs.pop_front();
         b = obs_busy.pop_front();
         x = exp_q.pop_front();
         chk({name, "_kind"}, 32'(e.is_valid), 32'(x.is_valid));
         chk({name, "_dout"}, 32'(e.data), 32'(x.data));
         chk({name, "_busy_at_strobe"}, 32'(b), 32'd0);
      end
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{8'hA5, 1'b1, 1, 1'b0};
      vecs[1] = '{8'h00, 1'b1, 0, 1'b0};
      vecs[2] = '{8'hFF, 1'b1, 1, 1'b0};
      vecs[3] = '{8'hC3, 1'b1, 1, 1'b1};
      vecs[4] = '{8'h3C, 1'b0, 1, 1'b0};
      vecs[5] = '{8'h5A, 1'b1, 2, 1'b1};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_dout", 32'(dout), 32'd0);
      chk("reset_valid", 32'(rx_valid), 32'd0);
      chk("reset_busy", 32'(rx_busy), 32'd0);
      chk("reset_ferr", 32'(frame_err), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      fork
         send_frame(8'hA5, 1'b1, 1, 1'b0, 1'b1);
         begin
            #(BIT_NS * 5);
            @(negedge clk);
            chk("busy_mid_frame", 32'(rx_busy), 32'd1);
         end
      join
      drain("a5");

      for (int i = 0; i < 6; i++) begin
         send_frame(vecs[i].data, vecs[i].stop, vecs[i].gap, vecs[i].jit, 1'b1);
         drain($sformatf("vec%0d", i));
      end

      // Short low pulse: start is rejected at mid-bit
      @(posedge clk); #1 rx = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("glitch_busy_rises", 32'(rx_busy), 32'd1);
      #1 rx = 1'b1;
      repeat (20) @(negedge clk);
      chk("glitch_busy_falls", 32'(rx_busy), 32'd0);
      chk("glitch_no_event", 32'(obs.size()), 32'd0);

      // Break: bad stop then line held low must not restart
      send_frame(8'h3C, 1'b0, 0, 1'b0, 1'b1);
      #(100 * CLK_NS);
      drain("break_err");
      @(negedge clk);
      chk("break_idle", 32'(rx_busy), 32'd0);
      chk("break_no_restart", 32'(obs.size()), 32'd0);
      rx = 1'b1;
      #(BIT_NS);
      send_frame(8'h81, 1'b1, 1, 1'b0, 1'b1);
      drain("after_break");

      // Reset during data bit 4, held until the partial frame has passed
      fork
         send_frame(8'h55, 1'b1, 1, 1'b0, 1'b0);
         begin
            #(BIT_NS * 5 + BIT_NS / 2);
            @(posedge clk); #1 rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("midreset_dout", 32'(dout), 32'd0);
            chk("midreset_busy", 32'(rx_busy), 32'd0);
            chk("midreset_valid", 32'(rx_valid), 32'd0);
         end
      join
      model_dout = '0;
      @(posedge clk); #1 rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("midreset_no_event", 32'(obs.size()), 32'd0);
      send_frame(8'h12, 1'b1, 1, 1'b0, 1'b1);
      drain("after_reset");

      for (int i = 0; i < 24; i++) begin
         logic [DL-1:0] d;
         logic          s;
         d = DL'($urandom);
         s = ($urandom_range(0, 3) != 0);
         send_frame(d, s, s ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2)),
                    bit'($urandom_range(0, 1)), 1'b1);
         drain($sformatf("rand%0d", i));
      end

      repeat (40) @(negedge clk);
      chk("no_stray_events", 32'(obs.size()), 32'd0);
      chk("strobe_overlap", 32'(overlap), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
